// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte buffer behind the UART receiver with occupancy/threshold/overflow status.
// Define UART_RX_FIFO_FWFT_EN for a first-word-fall-through read port; default is a registered read port.
module uart_rx_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_tick,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_overflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AFULL_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wp, rp;
    logic [ADDR_W:0]   count_nxt;
    logic              rd_acc, wr_acc, drop;

    // a full FIFO still accepts a write when a read frees a slot in the same cycle
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_tick && (!full || rd_acc);
    assign drop   = wr_tick && full && !rd_acc;

    always_comb begin
        count_nxt = (wr_acc && !rd_acc) ? count + 1'b1 :
                    (rd_acc && !wr_acc) ? count - 1'b1 : count;
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wp] <= wr_data;
    end

    // flags derive from next-state count so they never lag count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp          <= '0;
            rp          <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wp          <= wr_acc ? wp + 1'b1 : wp;
            rp          <= rd_acc ? rp + 1'b1 : rp;
            count       <= count_nxt;
            empty       <= count_nxt == '0;
            full        <= count_nxt == FULL_LVL;
            almost_full <= count_nxt >= AF_LVL;
            overflow    <= drop ? 1'b1 : clr_overflow ? 1'b0 : overflow;
        end
    end

`ifdef UART_RX_FIFO_FWFT_EN
    assign rd_valid = !empty;
    assign rd_data  = mem[rp];
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_acc;
            rd_data  <= rd_acc ? mem[rp] : rd_data;
        end
    end
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo, default (registered read port) build.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_tick = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, empty, full, almost_full, overflow;
    logic [4:0] count;
    int         vectors = 0;
    int         miscompares = 0;

    uart_rx_fifo dut (
        .clk(clk), .reset_n(reset_n), .wr_tick(wr_tick), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
        .full(full), .almost_full(almost_full), .count(count),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr_tick = 1'b0;
        rd_en = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        wr_tick = 1'b1;
        wr_data = d;
        tick();
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        rd_en = 1'b1;
        tick();
        check({tag, "_valid"}, 32'(rd_valid), 1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) push(base + 8'(i));
    endtask

    initial begin
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_data", 32'(rd_data), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("w3_count", 32'(count), 3);
        check("w3_empty", 32'(empty), 0);
        pop("r1", 8'h11);
        pop("r2", 8'h22);
        check("r2_empty", 32'(empty), 0);
        pop("r3", 8'h33);
        check("r3_count", 32'(count), 0);
        check("r3_empty", 32'(empty), 1);
        tick();
        check("idle_valid", 32'(rd_valid), 0);
        check("idle_hold", 32'(rd_data), 32'h33);

        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_afull", 32'(almost_full), 32'(i + 1 >= 12));
            check("fill_full", 32'(full), 32'(i + 1 == 16));
        end
        push(8'hAA);
        check("drop_ovf", 32'(overflow), 1);
        check("drop_count", 32'(count), 16);
        for (int i = 0; i < 16; i++) pop("drain", 8'(i));
        check("drain_empty", 32'(empty), 1);
        check("drain_afull", 32'(almost_full), 0);

        clr_overflow = 1'b1;
        tick();
        check("clr_ovf", 32'(overflow), 0);
        fill(8'h80);
        rd_en = 1'b1;
        wr_tick = 1'b1;
        wr_data = 8'h55;
        tick();
        check("rw_full_data", 32'(rd_data), 32'h80);
        check("rw_full_ovf", 32'(overflow), 0);
        check("rw_full_count", 32'(count), 16);
        check("rw_full_full", 32'(full), 1);
        for (int i = 1; i < 16; i++) pop("wrap", 8'h80 + 8'(i));
        pop("wrap_last", 8'h55);
        check("wrap_empty", 32'(empty), 1);

        rd_en = 1'b1;
        wr_tick = 1'b1;
        wr_data = 8'h77;
        tick();
        check("rw_empty_valid", 32'(rd_valid), 0);
        check("rw_empty_count", 32'(count), 1);
        pop("rw_empty_rd", 8'h77);
        rd_en = 1'b1;
        tick();
        check("rd_empty_valid", 32'(rd_valid), 0);
        check("rd_empty_count", 32'(count), 0);

        fill(8'h40);
        push(8'hEE);
        check("ovf_set", 32'(overflow), 1);
        wr_tick = 1'b1;
        wr_data = 8'hEF;
        clr_overflow = 1'b1;
        tick();
        check("ovf_prio", 32'(overflow), 1);
        check("ovf_prio_count", 32'(count), 16);
        clr_overflow = 1'b1;
        tick();
        check("ovf_clr", 32'(overflow), 0);

        rd_en = 1'b1;
        wr_tick = 1'b1;
        wr_data = 8'h5A;
        tick();
        check("pre_rst_valid", 32'(rd_valid), 1);
        check("pre_rst_data", 32'(rd_data), 32'h40);
        rd_en = 1'b1;
        wr_tick = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_full", 32'(full), 0);
        check("mid_rst_afull", 32'(almost_full), 0);
        check("mid_rst_valid", 32'(rd_valid), 0);
        check("mid_rst_data", 32'(rd_data), 0);
        rd_en = 1'b0;
        wr_tick = 1'b0;
        tick();
        reset_n = 1'b1;
        push(8'h99);
        check("post_rst_count", 32'(count), 1);
        pop("post_rst", 8'h99);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer directly downstream of the UART receiver. Captures each received byte on the receiver's one-cycle done strobe, holds up to 2^ADDR_W bytes and presents them to the host/bus side through a pop-style read interface with occupancy, threshold and sticky overflow status. It decouples the bit-serial receive timing from host read latency so that back-to-back frames are not lost.

## Interface
- DATA_W, 8, width of one received word (matches receiver output width)
- ADDR_W, 4, pointer width; depth = 2^ADDR_W entries (16)
- AFULL_LVL, 12, almost_full asserts when count >= AFULL_LVL; legal range 1..2^ADDR_W
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_tick  in  1  write strobe, driven from the receiver's rx_done_tick; one write per high cycle
- wr_data  in  DATA_W  byte to store, driven from the receiver's rx_dout; sampled when wr_tick high
- rd_en  in  1  pop request from the consumer
- rd_data  out  DATA_W  read word (meaning depends on configuration)
- rd_valid  out  1  rd_data qualifier (meaning depends on configuration)
- empty  out  1  count == 0
- full  out  1  count == 2^ADDR_W
- almost_full  out  1  count >= AFULL_LVL
- count  out  ADDR_W+1  current occupancy, 0..2^ADDR_W
- overflow  out  1  sticky: a write was dropped
- clr_overflow  in  1  synchronous clear of overflow

## Operation
- Storage: 2^ADDR_W x DATA_W array, write pointer wp and read pointer rp (ADDR_W bits each, natural wrap from 2^ADDR_W-1 to 0), occupancy counter count (ADDR_W+1 bits). Array contents are not reset.
- Write accept: wr_tick && (!full || rd_accept). Accepted word stored at wp, wp increments.
- Write drop: wr_tick && full && !rd_accept -> word discarded, pointers/count unchanged, overflow set.
- Read accept (rd_accept): rd_en && !empty. rp increments. rd_en while empty is ignored, no state change.
- Simultaneous accepted read and write: count unchanged; when empty, only the write takes effect; when full, both take effect (no drop).
- count: +1 on write only, -1 on read only, unchanged otherwise; never exceeds 2^ADDR_W or goes below 0.
- Flags empty/full/almost_full are registered, computed from next-state count, so they are consistent with count every cycle.
- overflow: set on drop, cleared by clr_overflow; set has priority when both occur in the same cycle.
- Reset (asserted at any time, including mid-burst): wp=rp=0, count=0, empty=1, full=0, almost_full=0, overflow=0, rd_valid=0, rd_data=0. Partially read data is discarded.

## Timing
- Write to visibility: wr_tick high at edge N -> count/empty updated after edge N; word readable from cycle N+1.
- Back-to-back wr_tick on consecutive cycles is supported at full rate.
- Standard mode: rd_accept at edge N -> rd_data loaded and rd_valid high for exactly one cycle after edge N; rd_data holds its value until the next accepted read; rd_valid low otherwise.
- FWFT mode: rd_valid = !empty; rd_data = array[rp] whenever rd_valid high; rd_en acts as acknowledge, next word (or empty) visible after the same edge. rd_data undefined-but-stable while empty.
- Throughput: one read and one write per cycle in both modes.

## Configuration
- UART_RX_FIFO_FWFT_EN defined: first-word-fall-through read port as described above (zero-latency head presentation, rd_valid mirrors !empty).
- Not defined: standard registered read port, one-cycle read latency, rd_valid one-cycle pulse per accepted read.
- All other behaviour (flags, count, overflow, reset) identical in both builds.

## Test plan
- Reset with random pointers: assert reset_n low mid-traffic -> count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0x00 immediately, no clock required.
- Write 0x11,0x22,0x33 on consecutive cycles, then read three -> data out 0x11,0x22,0x33 in order; count 3 -> 0; empty re-asserts after third read (standard: rd_valid pulses one cycle after each rd_en; FWFT: rd_data=0x11 one cycle after first write).
- Fill 16 words (0x00..0x0F) -> almost_full rises when count reaches 12, full at 16; 17th write 0xAA -> dropped, overflow=1, count stays 16; drain returns 0x00..0x0F, no 0xAA.
- Full FIFO with rd_en and wr_tick (0x55) same cycle -> no drop, overflow stays 0, count stays 16, 0x55 emerges last after wrap-around of wp/rp.
- Empty FIFO with rd_en and wr_tick (0x77) same cycle -> read ignored, count=1, next read returns 0x77; rd_en on empty alone -> no rd_valid pulse, count stays 0.
- overflow set and clr_overflow asserted in same cycle as a new drop -> overflow remains 1; clr_overflow alone next cycle -> overflow=0.
